// File: rtl/cache_req_arbiter_pkg.sv
// Shared widths and the outstanding-tag table entry for the cache request arbiter.
// Defaults here are the widths the top and interface parameters fall back to.
package cache_arb_pkg;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int ID_W      = 3;
    localparam int TAG_W     = 3;
    localparam int NUM_TAGS  = 2 ** TAG_W;
    // Requester index field sized for the largest supported NUM_REQ (4).
    localparam int REQ_IDX_W = 2;

    typedef struct packed {
        logic                 busy;
        logic [REQ_IDX_W-1:0] req_idx;
        logic [ID_W-1:0]      id;
    } tag_entry_t;

endpackage

// File: rtl/cache_req_arbiter_if.sv
// Requester-side and cache-side bundle of the cache request arbiter.
// slave is the arbiter's view; master is the view of the surrounding core and cache.
interface cache_req_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = cache_arb_pkg::ADDR_W,
    parameter int DATA_W  = cache_arb_pkg::DATA_W,
    parameter int ID_W    = cache_arb_pkg::ID_W,
    parameter int TAG_W   = cache_arb_pkg::TAG_W
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_rw;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*ID_W-1:0]   req_id;
    logic [NUM_REQ-1:0]        req_grant;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;

    logic [ADDR_W-1:0]         c_addr_in;
    logic [DATA_W-1:0]         c_data_in;
    logic                      c_rw_in;
    logic                      c_valid_in;
    logic [TAG_W-1:0]          c_id_in;
    logic [DATA_W-1:0]         c_data_out;
    logic [TAG_W-1:0]          c_id_out;
    logic                      c_ready_out;
    logic                      c_stall_out;

    logic [TAG_W:0]            outstanding;
    logic                      err;

    modport slave (
        input  req_valid, req_rw, req_addr, req_data, req_id,
        input  c_data_out, c_id_out, c_ready_out, c_stall_out,
        output req_grant, rsp_valid, rsp_id, rsp_data,
        output c_addr_in, c_data_in, c_rw_in, c_valid_in, c_id_in,
        output outstanding, err
    );

    modport master (
        output req_valid, req_rw, req_addr, req_data, req_id,
        output c_data_out, c_id_out, c_ready_out, c_stall_out,
        input  req_grant, rsp_valid, rsp_id, rsp_data,
        input  c_addr_in, c_data_in, c_rw_in, c_valid_in, c_id_in,
        input  outstanding, err
    );

endinterface

// File: rtl/cache_req_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past each winner.
// Latency 0; en_i low forces all grants low and freezes the pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic             found;

    // Scan offsets from the pointer; the first requesting slot wins.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (en_i && !found && req_i[i] && (i == ((int'(ptr_q) + k) % NUM_REQ))) begin
                    found    = 1'b1;
                    gnt_o[i] = 1'b1;
                    ptr_d    = PTR_W'((i + 1) % NUM_REQ);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cache_req_arbiter.sv
// Shares one cache request port among NUM_REQ requesters, retagging via an outstanding-tag table.
// Grant->c_valid_in 1 cycle, c_ready_out->rsp_valid 1 cycle; grants stop on cache stall or a full table.
module cache_req_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = cache_arb_pkg::ADDR_W,
    parameter int DATA_W  = cache_arb_pkg::DATA_W,
    parameter int ID_W    = cache_arb_pkg::ID_W,
    parameter int TAG_W   = cache_arb_pkg::TAG_W
) (
    input  logic               clk,
    input  logic               reset,
    cache_req_arbiter_if.slave bus
);

    import cache_arb_pkg::*;

    localparam int N_TAGS = 1 << TAG_W;

    tag_entry_t           tbl_q [N_TAGS];
    tag_entry_t           tbl_d [N_TAGS];

    logic [NUM_REQ-1:0]   gnt;
    logic                 grant_any;
    logic                 slot_free;
    logic                 free_found;
    logic [TAG_W-1:0]     free_tag;
    logic [REQ_IDX_W-1:0] gnt_idx;

    tag_entry_t           cmp_entry;
    logic                 cmp_ok;
    logic                 cmp_bad;

    logic                 c_valid_q, c_valid_d;
    logic                 c_rw_q,    c_rw_d;
    logic [ADDR_W-1:0]    c_addr_q,  c_addr_d;
    logic [DATA_W-1:0]    c_data_q,  c_data_d;
    logic [TAG_W-1:0]     c_id_q,    c_id_d;

    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q,    rsp_id_d;
    logic [DATA_W-1:0]    rsp_data_q,  rsp_data_d;
    logic                 err_q,       err_d;
    logic [TAG_W:0]       outst_q,     outst_d;

    // The slot can take a new request if empty or being drained this cycle.
    assign slot_free = !c_valid_q || !bus.c_stall_out;

    always_comb begin
        free_found = 1'b0;
        free_tag   = '0;
        for (int t = 0; t < N_TAGS; t++) begin
            if (!free_found && !tbl_q[t].busy) begin
                free_found = 1'b1;
                free_tag   = TAG_W'(t);
            end
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk   (clk),
        .reset (reset),
        .req_i (bus.req_valid),
        .en_i  (slot_free && free_found),
        .gnt_o (gnt)
    );

    assign grant_any = |gnt;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) gnt_idx = REQ_IDX_W'(i);
        end
    end

    assign cmp_entry = tbl_q[bus.c_id_out];
    assign cmp_ok    = bus.c_ready_out && cmp_entry.busy;
    assign cmp_bad   = bus.c_ready_out && !cmp_entry.busy;

    always_comb begin
        tbl_d = tbl_q;
        // A completion frees its tag only from the next cycle; the grant uses this cycle's free set.
        if (cmp_ok) tbl_d[bus.c_id_out].busy = 1'b0;
        if (grant_any) begin
            tbl_d[free_tag].busy    = 1'b1;
            tbl_d[free_tag].req_idx = gnt_idx;
            tbl_d[free_tag].id      = bus.req_id[gnt_idx*ID_W +: ID_W];
        end

        c_valid_d = c_valid_q;
        c_rw_d    = c_rw_q;
        c_addr_d  = c_addr_q;
        c_data_d  = c_data_q;
        c_id_d    = c_id_q;
        if (grant_any) begin
            c_valid_d = 1'b1;
            c_rw_d    = bus.req_rw[gnt_idx];
            c_addr_d  = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
            c_data_d  = bus.req_data[gnt_idx*DATA_W +: DATA_W];
            c_id_d    = free_tag;
        end else if (c_valid_q && !bus.c_stall_out) begin
            c_valid_d = 1'b0;
        end

        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_d[i] = cmp_ok && (cmp_entry.req_idx == REQ_IDX_W'(i));
        end
        if (cmp_ok) begin
            rsp_id_d   = cmp_entry.id;
            rsp_data_d = bus.c_data_out;
        end

        err_d = err_q | cmp_bad;

        case ({grant_any, cmp_ok})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int t = 0; t < N_TAGS; t++) tbl_q[t] <= '0;
            c_valid_q   <= 1'b0;
            c_rw_q      <= 1'b0;
            c_addr_q    <= '0;
            c_data_q    <= '0;
            c_id_q      <= '0;
            rsp_valid_q <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
            outst_q     <= '0;
        end else begin
            tbl_q       <= tbl_d;
            c_valid_q   <= c_valid_d;
            c_rw_q      <= c_rw_d;
            c_addr_q    <= c_addr_d;
            c_data_q    <= c_data_d;
            c_id_q      <= c_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
            outst_q     <= outst_d;
        end
    end

    assign bus.req_grant   = gnt;
    assign bus.c_valid_in  = c_valid_q;
    assign bus.c_rw_in     = c_rw_q;
    assign bus.c_addr_in   = c_addr_q;
    assign bus.c_data_in   = c_data_q;
    assign bus.c_id_in     = c_id_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.err         = err_q;
    assign bus.outstanding = outst_q;

endmodule

// File: doc/cache_req_arbiter.md
# cache_req_arbiter

Shares the single request port of `cache_subsystem` between `NUM_REQ` requesters, such as the ld/st queue and the fetch unit. A round-robin arbiter picks one requester per cycle. The winning request is retagged with a free cache id taken from an `2**TAG_W`-entry outstanding-tag table, and each cache completion is routed back to its originating requester with that requester's original id restored. The block sits between the core-side request queues and `cache_subsystem`.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (2..4)
- `ADDR_W`, 32: address width
- `DATA_W`, 32: data width
- `ID_W`, 3: requester-side id width
- `TAG_W`, 3: cache-side id width; the outstanding table has `2**TAG_W` entries

Ports:
- `clk`  in  1  clock; all logic on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  per-requester request valid
- `req_rw`  in  NUM_REQ  1 = write, 0 = read
- `req_addr`  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice i
- `req_data`  in  NUM_REQ*DATA_W  packed write data
- `req_id`  in  NUM_REQ*ID_W  packed requester ids
- `req_grant`  out  NUM_REQ  one-hot; request accepted this cycle
- `rsp_valid`  out  NUM_REQ  one-hot, single-cycle completion strobe
- `rsp_id`  out  ID_W  original requester id of the completion
- `rsp_data`  out  DATA_W  read data; don't-care for writes
- `c_addr_in`, `c_data_in`  out  ADDR_W / DATA_W  to cache `addr_in` / `data_in`
- `c_rw_in`  out  1  to cache `rw_in`
- `c_valid_in`  out  1  to cache `valid_in`
- `c_id_in`  out  TAG_W  to cache `id_in`
- `c_data_out`  in  DATA_W  from cache `data_out`
- `c_id_out`  in  TAG_W  from cache `id_out`
- `c_ready_out`  in  1  from cache `ready_out`
- `c_stall_out`  in  1  from cache `stall_out`
- `outstanding`  out  TAG_W+1  count of tags currently allocated
- `err`  out  1  sticky protocol error

## Operation
- Every cache request, read or write, produces exactly one `c_ready_out` pulse carrying its tag.
- **Request handshake:** a requester holds `req_valid` and its payload stable until it sees `req_grant[i]` high. It is accepted on that edge.
- **Grant conditions:** a grant is issued when all three hold:
  - the output slot is free, meaning `c_valid_in`=0, or `c_valid_in`=1 and `c_stall_out`=0;
  - at least one tag is free;
  - at least one `req_valid` is high.
- **Round-robin:** a priority pointer starts at 0. After a grant to requester i, the pointer moves to (i+1) mod `NUM_REQ`. The pointer does not move when nothing is granted.
- **Tag allocation:** the lowest-index free tag is chosen. The table entry stores {busy=1, requester index, `req_id`}.
- **Output register:** on a grant, `c_addr_in`/`c_data_in`/`c_rw_in`/`c_id_in` load and `c_valid_in`=1 the next cycle.
  - The cache accepts in a cycle with `c_valid_in`=1 and `c_stall_out`=0.
  - While stalled, all cache-side outputs hold.
  - `c_valid_in` clears after acceptance unless a new grant refills the slot in the same cycle.
- **Completion:** when `c_ready_out`=1, look up entry `c_id_out`. The next cycle, drive `rsp_valid[entry.req]`=1, `rsp_id`=entry.id and `rsp_data`=`c_data_out`, then clear busy.
- **Errors:** a completion on a non-busy tag is dropped, sets `err`, and leaves the table unchanged. `err` clears only on reset.
- **`outstanding`:** counts +1 per grant and −1 per valid completion; both in one cycle leaves it unchanged.

## Timing
- **Reset values:**
  - `req_grant`, `rsp_valid`, `c_valid_in`, `err`, `outstanding`, `c_rw_in`: 0
  - `c_addr_in`, `c_data_in`, `c_id_in`, `rsp_id`, `rsp_data`: 0
  - table: all tags free; pointer: 0
- `req_grant` is combinational from the current state and inputs.
- Grant to `c_valid_in`: 1 cycle.
- `c_ready_out` to `rsp_valid`: 1 cycle.
- A tag freed by a completion at edge N can be granted in cycle N+1, not in the same cycle. Completion and grant in one cycle touching different tags are both honoured.
- Table full: all grants are 0 until a completion frees a tag.
- Reset asserted mid-operation discards all outstanding entries. No `rsp_valid` is issued for them.

## Structure
- Package `cache_arb_pkg` holds:
  - the width constants `ADDR_W`, `DATA_W`, `ID_W`, `TAG_W`;
  - the table entry typedef {busy, req_idx, id};
  - `NUM_TAGS = 2**TAG_W`.
- Sub-module `rr_arbiter`: parameterised `NUM_REQ` round-robin, with request vector in, enable in, one-hot grant out, and the pointer state held inside.
- The tag table, free-tag priority encoder, output register and response register live in the top module.

## Test plan
- **Single read:** requester 0 reads addr 0x10, id 5 → `c_valid_in` the next cycle with `c_id_in`=0; cache returns tag 0 with data 0x4 → `rsp_valid`=01, `rsp_id`=5, `rsp_data`=0x4 one cycle later.
- **Contention:** both requesters hold valid continuously for 8 grants → grants alternate 01, 10, 01, … and tags are assigned 0..7 in order.
- **Table full:** 8 grants with no completions → `outstanding`=8 and no grant. Complete tag 3 → the next grant gets tag 3 one cycle after the completion.
- **Stall:** `c_stall_out`=1 for 5 cycles while `c_valid_in`=1 → cache-side outputs hold, no `req_grant`, no lost or duplicated request.
- **Out-of-order completion:** complete tags 2, 0, 1 → responses are routed to the correct requesters with their original ids, and `outstanding` decrements to 0.
- **Error and reset:** a completion on a free tag sets `err` and changes nothing else. Reset asserted with 4 outstanding → all outputs return to zero and no responses follow.
